// File: rtl/pc_gen_if.sv
// Fetch-side bundle of pc_gen: pipeline control/redirect inputs and the fetch request.
// The master side is the PC generator; the slave side is the pipeline/imem model.
interface pc_gen_if #(
   parameter int XLEN = 32
);
   logic            stall;
   logic            flush_req;
   logic [XLEN-1:0] flush_target;
   logic            redir_valid;
   logic [XLEN-1:0] redir_target;
   logic            fetch_ready;
   logic [XLEN-1:0] pc;
   logic            pc_valid;
   logic [XLEN-1:0] pc_seq;
   logic            misalign_err;

   modport master (
      input  stall, flush_req, flush_target, redir_valid, redir_target, fetch_ready,
      output pc, pc_valid, pc_seq, misalign_err
   );

   modport slave (
      output stall, flush_req, flush_target, redir_valid, redir_target, fetch_ready,
      input  pc, pc_valid, pc_seq, misalign_err
   );
endinterface

// File: rtl/pc_gen.sv
// Program-counter generator with boot delay, fetch handshake and latched redirects.
// Define PC_ALIGN_CHECK_EN to reject misaligned flush/redirect targets and pulse misalign_err.
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter int              INC          = 4,
   parameter int              BOOT_DELAY   = 2
) (
   input  logic     clk,
   input  logic     rst,
   pc_gen_if.master bus
);
   localparam logic [0:0] ST_BOOT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;
   localparam logic [0:0] ST_INIT = (BOOT_DELAY == 0) ? ST_RUN : ST_BOOT;

   localparam int              CNT_W      = (BOOT_DELAY > 2) ? $clog2(BOOT_DELAY) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((BOOT_DELAY > 0) ? BOOT_DELAY - 1 : 0);
   localparam logic [XLEN-1:0] STEP       = XLEN'(INC);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);

   logic [0:0]       state_q;
   logic [CNT_W-1:0] boot_cnt_q;
   logic [XLEN-1:0]  pc_q, pc_nxt;
   logic             pend_valid_q, pend_valid_nxt;
   logic [XLEN-1:0]  pend_target_q, pend_target_nxt;
   logic             advance;
   logic             flush_bad, redir_bad, redir_take;

`ifdef PC_ALIGN_CHECK_EN
   logic misalign_q;

   assign flush_bad = |(bus.flush_target & ALIGN_MASK);
   assign redir_bad = |(bus.redir_target & ALIGN_MASK);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) misalign_q <= 1'b0;
      else      misalign_q <= bus.flush_req ? flush_bad : (bus.redir_valid & redir_bad);
   end

   assign bus.misalign_err = misalign_q;
`else
   assign flush_bad        = 1'b0;
   assign redir_bad        = 1'b0;
   assign bus.misalign_err = 1'b0;
`endif

   assign advance    = (state_q == ST_RUN) & ~bus.stall & bus.fetch_ready;
   assign redir_take = bus.redir_valid & ~redir_bad;

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      pc_nxt          = pc_q;
      pend_valid_nxt  = pend_valid_q;
      pend_target_nxt = pend_target_q;
      if (bus.flush_req) begin
         pend_valid_nxt = 1'b0;
         if (!flush_bad) pc_nxt = bus.flush_target;
      end else if (redir_take && advance) begin
         pc_nxt         = bus.redir_target;
         pend_valid_nxt = 1'b0;
      end else if (redir_take) begin
         pend_target_nxt = bus.redir_target;
         pend_valid_nxt  = 1'b1;
      end else if (pend_valid_q && advance) begin
         pc_nxt         = pend_target_q;
         pend_valid_nxt = 1'b0;
      end else if (advance) begin
         pc_nxt = pc_q + STEP;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= ST_INIT;
         boot_cnt_q    <= '0;
         pc_q          <= RESET_VECTOR;
         pend_valid_q  <= 1'b0;
         pend_target_q <= '0;
      end else begin
         if (state_q == ST_BOOT) begin
            if (boot_cnt_q == CNT_LAST) state_q <= ST_RUN;
            boot_cnt_q <= boot_cnt_q + 1'b1;
         end
         pc_q          <= pc_nxt;
         pend_valid_q  <= pend_valid_nxt;
         pend_target_q <= pend_target_nxt;
      end
   end

   // Gated by rst so a zero boot delay still shows no request while reset is held.
   assign bus.pc_valid = (state_q == ST_RUN) & rst;
   assign bus.pc       = pc_q;
   assign bus.pc_seq   = pc_q + STEP;
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios then randomized traffic,
// all compared against a cycle-level reference model of the fetch PC rules.
module tb_pc_gen;
   localparam int          XLEN = 32;
   localparam logic [31:0] RV   = 32'h0000_0000;
   localparam int          INC  = 4;
   localparam int          BD   = 2;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   pc_gen_if #(.XLEN(XLEN)) bus ();

   pc_gen #(.XLEN(XLEN), .RESET_VECTOR(RV), .INC(INC), .BOOT_DELAY(BD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state: pending redirect is a queue holding at most one target.
   logic [31:0] m_pc;
   logic [31:0] m_pend[$];
   int          m_boot_left;
   logic        m_mis;

`ifdef PC_ALIGN_CHECK_EN
   localparam bit ALIGN_EN = 1'b1;
`else
   localparam bit ALIGN_EN = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".pc"},       bus.pc,                    m_pc);
      check({tag, ".pc_valid"}, {31'd0, bus.pc_valid},     {31'd0, m_boot_left == 0 && rst});
      check({tag, ".pc_seq"},   bus.pc_seq,                m_pc + INC);
      check({tag, ".misalign"}, {31'd0, bus.misalign_err}, {31'd0, m_mis});
   endtask

   task automatic m_reset();
      m_pc        = RV;
      m_pend.delete();
      m_boot_left = BD;
      m_mis       = 1'b0;
   endtask

   // Apply one clock edge to the model using the inputs currently driven.
   task automatic m_edge();
      bit valid, adv, bad_f, bad_r;
      valid = (m_boot_left == 0);
      adv   = valid && !bus.stall && bus.fetch_ready;
      bad_f = ALIGN_EN && (bus.flush_target % INC != 0);
      bad_r = ALIGN_EN && (bus.redir_target % INC != 0);
      if (m_boot_left > 0) m_boot_left--;
      m_mis = 1'b0;
      if (bus.flush_req) begin
         m_pend.delete();
         if (bad_f) m_mis = 1'b1;
         else       m_pc  = bus.flush_target;
      end else begin
         if (bus.redir_valid && bad_r) m_mis = 1'b1;
         if (bus.redir_valid && !bad_r) begin
            m_pend.delete();
            if (adv) m_pc = bus.redir_target;
            else     m_pend.push_back(bus.redir_target);
         end else if (m_pend.size() > 0 && adv) begin
            m_pc = m_pend.pop_front();
         end else if (adv) begin
            m_pc = m_pc + INC;
         end
      end
   endtask

   task automatic drive(input bit st, input bit fl, input logic [31:0] ft,
                        input bit rv, input logic [31:0] rt, input bit fr);
      bus.stall        = st;
      bus.flush_req    = fl;
      bus.flush_target = ft;
      bus.redir_valid  = rv;
      bus.redir_target = rt;
      bus.fetch_ready  = fr;
   endtask

   task automatic step(input string tag);
      m_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic async_reset(input string tag);
      #2 rst = 1'b0;
      m_reset();
      #1 check_all(tag);
      check({tag, ".rv"}, bus.pc, RV);
      #1 rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 1);
      m_reset();
      #12;
      check_all("reset");
      rst = 1'b1;

      // Boot delay, then sequential fetch 0, 4, 8, C, 10.
      step("boot0");
      step("boot1");
      check("boot_valid", {31'd0, bus.pc_valid}, 32'd1);
      step("seq4");
      step("seq8");
      step("seqC");
      check("seqC_pc", bus.pc, 32'h0000_000C);
      step("seq10");

      // Stall three cycles with a redirect arriving on the first stalled cycle.
      drive(1, 0, 0, 1, 32'h200, 1);
      step("stall1");
      drive(1, 0, 0, 0, 0, 1);
      step("stall2");
      step("stall3");
      check("stall_hold", bus.pc, 32'h10);
      drive(0, 0, 0, 0, 0, 1);
      step("pend_apply");
      check("pend_pc", bus.pc, 32'h200);
      step("after_pend");
      check("after_pend_pc", bus.pc, 32'h204);

      // Flush beats a simultaneous redirect while imem is not ready.
      drive(0, 1, 32'h40, 0, 0, 1);
      step("to40");
      drive(0, 1, 32'h80, 1, 32'h300, 0);
      step("flush_wins");
      check("flush_pc", bus.pc, 32'h80);
      drive(0, 0, 0, 0, 0, 0);
      step("not_ready_hold");
      drive(0, 0, 0, 0, 0, 1);
      step("redir_dropped");
      check("dropped_pc", bus.pc, 32'h84);

      // Wrap-around at the top of the address space.
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 1);
      step("to_top");
      check("top_seq", bus.pc_seq, 32'h0);
      drive(0, 0, 0, 0, 0, 1);
      step("wrap");
      check("wrap_pc", bus.pc, 32'h0);

      // Reset mid-run with a pending redirect: the pending target must be discarded.
      drive(0, 0, 0, 1, 32'h500, 0);
      step("pend_set");
      drive(0, 0, 0, 0, 0, 1);
      async_reset("mid_reset");
      step("rboot0");
      step("rboot1");
      step("rrun0");
      check("no_stale_pend", bus.pc, RV + INC);

      // Misaligned redirect target.
      drive(0, 1, 32'h20, 0, 0, 1);
      step("to20");
      drive(0, 0, 0, 1, 32'h102, 1);
      step("misalign");
      check("mis_pc", bus.pc, ALIGN_EN ? 32'h24 : 32'h102);
      check("mis_err", {31'd0, bus.misalign_err}, {31'd0, ALIGN_EN});
      drive(0, 0, 0, 0, 0, 1);
      step("mis_clear");

      // Randomized traffic with occasional asynchronous resets.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] ft, rt;
         ft = $urandom & ~32'h3;
         rt = $urandom & ~32'h3;
         if ($urandom_range(0, 7) == 0) ft[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 7) == 0) rt[1:0] = 2'($urandom_range(1, 3));
         drive($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, ft,
               $urandom_range(0, 4) == 0, rt, $urandom_range(0, 3) != 0);
         step("rand");
         if (i % 97 == 50) async_reset("rand_reset");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
